// File: rtl/pipelined_control_unit.sv
// Registered decode/control stage between IF/ID and ID/EX.
// Adds stall hold, flush bubbles, load-use detection, HALT drain and issue count.
module pipelined_control_unit #(
  parameter int ALUCTL_W     = 6,
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  I_CLK,
  input  logic                  I_RST_N,
  input  logic                  I_CU_VALID,
  input  logic [5:0]            I_CU_OP,
  input  logic [5:0]            I_CU_FUNCT,
  input  logic [REG_ADDR_W-1:0] I_CU_RS,
  input  logic [REG_ADDR_W-1:0] I_CU_RT,
  input  logic                  I_CU_STALL,
  input  logic                  I_CU_FLUSH,
  input  logic                  I_CU_EX_MEMREAD,
  input  logic [REG_ADDR_W-1:0] I_CU_EX_RT,
  output logic                  O_CU_VALID,
  output logic                  O_CU_MemtoReg,
  output logic                  O_CU_RegWrite,
  output logic                  O_CU_MemWrite,
  output logic                  O_CU_MemRead,
  output logic                  O_CU_BranchEQ,
  output logic                  O_CU_BranchNE,
  output logic                  O_CU_ALUSrc,
  output logic                  O_CU_RegDst,
  output logic                  O_CU_signed,
  output logic                  O_CU_shift,
  output logic                  O_CU_Jump,
  output logic                  O_CU_LinkR,
  output logic [ALUCTL_W-1:0]   O_CU_ALUControl,
  output logic [1:0]            O_CU_Trunk,
  output logic                  O_CU_HAZARD,
  output logic                  O_CU_HALTED,
  output logic [CNT_W-1:0]      O_CU_ICOUNT
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_HALT = 6'b010101;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_LWU  = 6'b100111;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_NOP  = 6'b111110;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  typedef struct packed {
    logic                valid;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_write;
    logic                mem_read;
    logic                branch_eq;
    logic                branch_ne;
    logic                alu_src;
    logic                reg_dst;
    logic                is_signed;
    logic                shift;
    logic                jump;
    logic                link_r;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic [1:0]          trunk;
  } ctl_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_e;

  ctl_t             dec;
  ctl_t             ctl_d, ctl_q;
  state_e           state_d, state_q;
  logic [3:0]       drain_d, drain_q;
  logic [CNT_W-1:0] icount_d, icount_q;
  logic             uses_rt;
  logic             hazard;
  logic [1:0]       mem_size;

  // Access size comes from the low opcode bits shared by loads and stores
  always_comb begin
    mem_size = 2'b00;
    unique case (I_CU_OP[1:0])
      2'b00:   mem_size = 2'b10;
      2'b01:   mem_size = 2'b01;
      default: mem_size = 2'b00;
    endcase
  end

  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    unique case (I_CU_OP)
      OP_R: begin
        dec.alu_ctl = ALUCTL_W'(I_CU_FUNCT);
        unique case (I_CU_FUNCT)
          FN_JR: dec.jump = 1'b1;
          FN_JALR: begin
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.shift      = 1'b1;
            dec.jump       = 1'b1;
            dec.link_r     = 1'b1;
          end
          default: begin
            dec.reg_write = 1'b1;
            dec.reg_dst   = 1'b1;
            uses_rt       = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctl   = ALUCTL_W'(6'b100001);
        dec.is_signed = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctl   = ALUCTL_W'({3'b100, I_CU_OP[2:0]});
        if (I_CU_OP == OP_SLTI)
          dec.alu_ctl = ALUCTL_W'(6'b101010);
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.shift     = 1'b1;
      end
      OP_BEQ: begin
        dec.branch_eq = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BNE: begin
        dec.branch_ne = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      OP_JAL: begin
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.shift      = 1'b1;
        dec.jump       = 1'b1;
        dec.link_r     = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_ctl    = ALUCTL_W'(6'b100001);
        dec.trunk      = mem_size;
        dec.is_signed  = ~I_CU_OP[2];
      end
      OP_SB, OP_SH, OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctl   = ALUCTL_W'(6'b100001);
        dec.is_signed = 1'b1;
        dec.trunk     = mem_size;
        uses_rt       = 1'b1;
      end
      OP_NOP: dec.alu_ctl = ALUCTL_W'(6'b111110);
      default: dec = '0;
    endcase
  end

  assign hazard = I_CU_VALID
                & (state_q == S_RUN)
                & I_CU_EX_MEMREAD
                & (I_CU_EX_RT != '0)
                & ((I_CU_EX_RT == I_CU_RS)
                 | ((I_CU_EX_RT == I_CU_RT) & uses_rt));

  always_comb begin
    ctl_d    = ctl_q;
    state_d  = state_q;
    drain_d  = drain_q;
    icount_d = icount_q;
    if (!I_CU_STALL) begin
      ctl_d = '0;
      // Drain lasts DRAIN_CYCLES bubble cycles, then one more edge raises HALTED
      if (state_q == S_DRAIN) begin
        if (drain_q == 4'd0)
          state_d = S_HALTED;
        else
          drain_d = drain_q - 4'd1;
      end
      if (!I_CU_FLUSH && !hazard &&
          state_q == S_RUN && I_CU_VALID) begin
        ctl_d       = dec;
        ctl_d.valid = 1'b1;
        if (icount_q != '1)
          icount_d = icount_q + CNT_W'(1);
        if (I_CU_OP == OP_HALT) begin
          state_d = S_DRAIN;
          drain_d = 4'(DRAIN_CYCLES);
        end
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      ctl_q    <= '0;
      state_q  <= S_RUN;
      drain_q  <= '0;
      icount_q <= '0;
    end else begin
      ctl_q    <= ctl_d;
      state_q  <= state_d;
      drain_q  <= drain_d;
      icount_q <= icount_d;
    end
  end

  assign O_CU_VALID      = ctl_q.valid;
  assign O_CU_MemtoReg   = ctl_q.mem_to_reg;
  assign O_CU_RegWrite   = ctl_q.reg_write;
  assign O_CU_MemWrite   = ctl_q.mem_write;
  assign O_CU_MemRead    = ctl_q.mem_read;
  assign O_CU_BranchEQ   = ctl_q.branch_eq;
  assign O_CU_BranchNE   = ctl_q.branch_ne;
  assign O_CU_ALUSrc     = ctl_q.alu_src;
  assign O_CU_RegDst     = ctl_q.reg_dst;
  assign O_CU_signed     = ctl_q.is_signed;
  assign O_CU_shift      = ctl_q.shift;
  assign O_CU_Jump       = ctl_q.jump;
  assign O_CU_LinkR      = ctl_q.link_r;
  assign O_CU_ALUControl = ctl_q.alu_ctl;
  assign O_CU_Trunk      = ctl_q.trunk;
  assign O_CU_HAZARD     = hazard;
  assign O_CU_HALTED     = (state_q == S_HALTED);
  assign O_CU_ICOUNT     = icount_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios plus random traffic
// against a behavioural model of decode, hazards, drain and issue count.
module tb_pipelined_control_unit;

  localparam int AW = 6;
  localparam int RW = 5;
  localparam int DC = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic          stall;
  logic          flush;
  logic          ex_mr;
  logic [RW-1:0] ex_rt;

  logic          o_valid, o_m2r, o_rw, o_mw, o_mr;
  logic          o_beq, o_bne, o_src, o_dst, o_sg;
  logic          o_sh, o_j, o_lr, o_haz, o_halted;
  logic [AW-1:0] o_alu;
  logic [1:0]    o_tr;
  logic [CW-1:0] o_cnt;

  always #5 clk = ~clk;

  pipelined_control_unit #(
    .ALUCTL_W(AW), .REG_ADDR_W(RW),
    .DRAIN_CYCLES(DC), .CNT_W(CW)
  ) dut (
    .I_CLK(clk),
    .I_RST_N(rst_n),
    .I_CU_VALID(valid),
    .I_CU_OP(op),
    .I_CU_FUNCT(funct),
    .I_CU_RS(rs),
    .I_CU_RT(rt),
    .I_CU_STALL(stall),
    .I_CU_FLUSH(flush),
    .I_CU_EX_MEMREAD(ex_mr),
    .I_CU_EX_RT(ex_rt),
    .O_CU_VALID(o_valid),
    .O_CU_MemtoReg(o_m2r),
    .O_CU_RegWrite(o_rw),
    .O_CU_MemWrite(o_mw),
    .O_CU_MemRead(o_mr),
    .O_CU_BranchEQ(o_beq),
    .O_CU_BranchNE(o_bne),
    .O_CU_ALUSrc(o_src),
    .O_CU_RegDst(o_dst),
    .O_CU_signed(o_sg),
    .O_CU_shift(o_sh),
    .O_CU_Jump(o_j),
    .O_CU_LinkR(o_lr),
    .O_CU_ALUControl(o_alu),
    .O_CU_Trunk(o_tr),
    .O_CU_HAZARD(o_haz),
    .O_CU_HALTED(o_halted),
    .O_CU_ICOUNT(o_cnt)
  );

  wire [20:0] obs = {o_valid, o_m2r, o_rw, o_mw, o_mr,
                     o_beq, o_bne, o_src, o_dst, o_sg,
                     o_sh, o_j, o_lr, o_alu, o_tr};

  int n_tests = 0;
  int n_fail  = 0;

  int         m_phase;
  int         m_left;
  int         m_cnt;
  logic [20:0] m_bun;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_size(input logic [5:0] o);
    case (o)
      6'h20, 6'h24, 6'h28: return 2'b10;
      6'h21, 6'h25, 6'h29: return 2'b01;
      default:             return 2'b00;
    endcase
  endfunction

  // {m2r,rw,mw,mr,beq,bne,src,dst,sg,sh,j,lr,alu[5:0],trunk[1:0]}
  function automatic logic [19:0] ref_dec(input logic [5:0] o,
                                          input logic [5:0] f);
    logic m2r, rw, mw, mr, beq, bne, src, dst, sg, sh, j, lr;
    logic [5:0] alu;
    logic [1:0] tr;
    {m2r, rw, mw, mr, beq, bne, src, dst, sg, sh, j, lr} = 12'b0;
    alu = 6'h00;
    tr  = 2'b00;
    case (o)
      6'h00: begin
        alu = f;
        if (f == 6'h08) j = 1'b1;
        else if (f == 6'h09) {m2r, rw, sh, j, lr} = 5'b11111;
        else {rw, dst} = 2'b11;
      end
      6'h08: begin rw = 1; src = 1; alu = 6'h21; sg = 1; end
      6'h0c: begin rw = 1; src = 1; alu = 6'h24; end
      6'h0d: begin rw = 1; src = 1; alu = 6'h25; end
      6'h0e: begin rw = 1; src = 1; alu = 6'h26; end
      6'h0a: begin rw = 1; src = 1; alu = 6'h2a; end
      6'h0f: begin rw = 1; src = 1; sh = 1; end
      6'h04: beq = 1'b1;
      6'h05: bne = 1'b1;
      6'h02: j = 1'b1;
      6'h03: {m2r, rw, sh, j, lr} = 5'b11111;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27: begin
        {m2r, rw, mr, src} = 4'b1111;
        alu = 6'h21;
        tr  = ref_size(o);
        sg  = (o == 6'h20 || o == 6'h21 || o == 6'h23);
      end
      6'h28, 6'h29, 6'h2b: begin
        {mw, src, sg} = 3'b111;
        alu = 6'h21;
        tr  = ref_size(o);
      end
      6'h3e: alu = 6'h3e;
      default: ;
    endcase
    return {m2r, rw, mw, mr, beq, bne, src, dst, sg,
            sh, j, lr, alu, tr};
  endfunction

  function automatic bit ref_uses_rt(input logic [5:0] o,
                                     input logic [5:0] f);
    if (o == 6'h00) return (f != 6'h08 && f != 6'h09);
    return (o == 6'h04 || o == 6'h05 || o == 6'h28 ||
            o == 6'h29 || o == 6'h2b);
  endfunction

  // One clock: check hazard mid-cycle, advance model, check registers after edge
  task automatic cycle();
    logic h;
    int   old;
    @(negedge clk);
    h = valid && m_phase == 0 && ex_mr && ex_rt != 0 &&
        (ex_rt == rs || (ex_rt == rt && ref_uses_rt(op, funct)));
    if (rst_n) check("hazard", 32'(o_haz), 32'(h));
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_cnt = 0; m_bun = '0;
    end else if (!stall) begin
      old   = m_phase;
      m_bun = '0;
      if (old == 1) begin
        if (m_left == 0) m_phase = 2;
        else m_left--;
      end
      if (!flush && !h && old == 0 && valid) begin
        m_bun = {1'b1, ref_dec(op, funct)};
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (op == 6'h15) begin
          m_phase = 1;
          m_left  = DC;
        end
      end
    end
    @(posedge clk);
    #1;
    check("bundle", 32'(obs), 32'(m_bun));
    check("halted", 32'(o_halted), 32'(m_phase == 2));
    check("icount", 32'(o_cnt), 32'(m_cnt));
  endtask

  task automatic idle();
    valid = 0; op = 0; funct = 0; rs = 0; rt = 0;
    stall = 0; flush = 0; ex_mr = 0; ex_rt = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    cycle();
    rst_n = 1;
  endtask

  logic [5:0] ops [24] = '{
    6'h00, 6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a,
    6'h0f, 6'h04, 6'h05, 6'h02, 6'h03, 6'h20, 6'h21, 6'h23,
    6'h24, 6'h25, 6'h27, 6'h28, 6'h29, 6'h2b, 6'h3e, 6'h3f};
  logic [5:0] fns [3] = '{6'h23, 6'h08, 6'h09};

  initial begin
    m_phase = 0; m_left = 0; m_cnt = 0; m_bun = '0;
    idle();
    rst_n = 0;
    valid = 1;
    op    = 6'h23;
    cycle();
    cycle();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_memread", 32'(o_mr), 32'd0);
    check("rst_icount", 32'(o_cnt), 32'd0);
    rst_n = 1;
    cycle();
    check("lw_memread", 32'(o_mr), 32'd1);
    check("lw_trunk", 32'(o_tr), 32'd0);
    check("lw_signed", 32'(o_sg), 32'd1);
    check("lw_alu", 32'(o_alu), 32'h21);
    check("lw_valid", 32'(o_valid), 32'd1);

    for (int i = 0; i < 24; i++) begin
      valid = 1;
      op    = ops[i];
      funct = (i < 3) ? fns[i] : 6'($urandom_range(0, 63));
      cycle();
    end
    check("unk_valid", 32'(o_valid), 32'd1);
    check("unk_bundle", 32'(obs[19:0]), 32'd0);

    ex_mr = 1; ex_rt = 5;
    op = 6'h00; funct = 6'h20; rs = 1; rt = 5;
    #1 check("haz_add", 32'(o_haz), 32'd1);
    cycle();
    check("haz_bubble", 32'(o_valid), 32'd0);
    op = 6'h08;
    #1 check("haz_addi", 32'(o_haz), 32'd0);
    cycle();
    op = 6'h00; ex_rt = 0; rt = 0;
    #1 check("haz_r0", 32'(o_haz), 32'd0);
    cycle();
    ex_mr = 0;

    op = 6'h0d; funct = 0;
    cycle();
    stall = 1;
    op = 6'h2b;
    repeat (3) cycle();
    check("stall_ori", 32'(o_alu), 32'h25);
    flush = 1;
    cycle();
    check("stall_flush", 32'(o_valid), 32'd1);
    stall = 0;
    cycle();
    check("flush", 32'(o_valid), 32'd0);

    do_reset();
    valid = 1; op = 6'h15;
    cycle();
    check("halt_issue", 32'(o_valid), 32'd1);
    check("halt_cnt", 32'(o_cnt), 32'd1);
    op = 6'h00; funct = 6'h20;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("drain_bubble", 32'(o_valid), 32'd0);
      check("drain_halted", 32'(o_halted), 32'(i == 3));
    end
    do_reset();
    valid = 1; op = 6'h15;
    cycle();
    op = 6'h00;
    cycle();
    stall = 1;
    cycle();
    stall = 0;
    cycle();
    cycle();
    check("stall_drain", 32'(o_halted), 32'd0);
    cycle();
    check("stall_halted", 32'(o_halted), 32'd1);
    do_reset();
    check("halt_rst", 32'(o_halted), 32'd0);

    valid = 1; op = 6'h3e;
    repeat (20) cycle();
    check("cnt_sat", 32'(o_cnt), 32'd15);

    do_reset();
    for (int k = 0; k < 500; k++) begin
      rst_n = ($urandom_range(0, 99) >= 3);
      valid = ($urandom_range(0, 99) < 80);
      op    = ($urandom_range(0, 99) < 4) ? 6'h15 :
              ops[$urandom_range(0, 23)];
      funct = ($urandom_range(0, 3) == 0) ? 6'h08 :
              ($urandom_range(0, 3) == 0) ? 6'h09 :
              6'($urandom_range(0, 63));
      rs    = RW'($urandom_range(0, 3));
      rt    = RW'($urandom_range(0, 3));
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 15);
      ex_mr = ($urandom_range(0, 1) == 1);
      ex_rt = RW'($urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
